x4xx_dio_multiport: RTL

X4XX_DIO_MULTIPORT -- requirements
Module: x4xx_dio_multiport

---
 rtl/x4xx_dio_multiport_pkg.sv | 38 +++
 rtl/glitch_free_mux.sv | 14 +
 rtl/synchronizer.sv | 29 ++
 rtl/x4xx_dio_line_filter.sv | 67 ++++++
 rtl/x4xx_dio_multiport.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/x4xx_dio_multiport_pkg.sv
// Shared constants for the multi-port DIO register block: register offsets
// within a port window, the window stride, and the port/width limits.
// Used by x4xx_dio_multiport; DIO_DEBOUNCE_EN selects the debounce filter.
package x4xx_dio_multiport_pkg;

  typedef logic [5:0] reg_offset_t;

  localparam int MAX_PORTS      = 8;
  localparam int MAX_PORT_WIDTH = 32;
  localparam int PORT_STRIDE    = 'h40;
  localparam int OFFSET_WIDTH   = $clog2(PORT_STRIDE);
  localparam int PORT_IDX_WIDTH = $clog2(MAX_PORTS);

  localparam reg_offset_t OFF_MASTER      = 6'h00;
  localparam reg_offset_t OFF_DIRECTION   = 6'h04;
  localparam reg_offset_t OFF_INPUT       = 6'h08;
  localparam reg_offset_t OFF_OUTPUT      = 6'h0C;
  localparam reg_offset_t OFF_OUTPUT_SET  = 6'h10;
  localparam reg_offset_t OFF_OUTPUT_CLR  = 6'h14;
  localparam reg_offset_t OFF_EDGE_STATUS = 6'h18;
  localparam reg_offset_t OFF_RISE_EN     = 6'h1C;
  localparam reg_offset_t OFF_FALL_EN     = 6'h20;

  // Every defined offset can be read (write-only ones simply return 0).
  function automatic logic offset_readable(reg_offset_t off);
    case (off)
      OFF_MASTER, OFF_DIRECTION, OFF_INPUT, OFF_OUTPUT, OFF_OUTPUT_SET,
      OFF_OUTPUT_CLR, OFF_EDGE_STATUS, OFF_RISE_EN, OFF_FALL_EN: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // INPUT is the only defined offset that refuses writes.
  function automatic logic offset_writable(reg_offset_t off);
    return offset_readable(off) && (off != OFF_INPUT);
  endfunction

endpackage

// File: rtl/glitch_free_mux.sv
// Per-bit 2:1 mux with the consensus term included, so the output does not
// glitch when the select toggles while both data inputs agree.
module glitch_free_mux #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = (sel & a) | (~sel & b) | (a & b);

endmodule

// File: rtl/synchronizer.sv
// Multi-stage flip-flop synchronizer for bringing asynchronous inputs into
// the clock domain. Resets every stage to 0.
module synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stages;

  // Shift the input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/x4xx_dio_line_filter.sv
// Per-port line filter: optional debounce (DIO_DEBOUNCE_EN) followed by a
// previous-value register producing one-cycle rise/fall pulses.
// Without DIO_DEBOUNCE_EN the synchronized value passes straight through.
module x4xx_dio_line_filter #(
  parameter int WIDTH           = 12,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] filtered,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] prev;

`ifdef DIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] count;
  logic [WIDTH-1:0]         stable;

  // Accept a new line value only after it has differed for the full window;
  // any return to the accepted value restarts that line's count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      stable <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_in[i] != stable[i]) begin
          if (count[i] == LAST_COUNT) begin
            stable[i] <= sync_in[i];
            count[i]  <= '0;
          end else begin
            count[i] <= count[i] + CW'(1);
          end
        end else begin
          count[i] <= '0;
        end
      end
    end
  end

  assign filtered = stable;
`else
  // The window length only matters when debouncing is built in.
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES > 0);
  assign filtered        = sync_in;
`endif

  // Remember last cycle's filtered value; edges are the difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= filtered;
    end
  end

  assign rise = filtered & ~prev;
  assign fall = ~filtered & prev;

endmodule

// File: rtl/x4xx_dio_multiport.sv
// Multi-port DIO register block on a ctrlport slave. Each port has a 0x40
// byte window with master/direction/output control, input readback, and
// edge-detect interrupt status. DIO_DEBOUNCE_EN adds an input debounce.
module x4xx_dio_multiport
  import x4xx_dio_multiport_pkg::*;
#(
  parameter int REG_BASE        = 0,
  parameter int NUM_PORTS       = 2,
  parameter int PORT_WIDTH      = 12,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                             ctrlport_clk,
  input  logic                             ctrlport_rst,
  input  logic                             s_ctrlport_req_wr,
  input  logic                             s_ctrlport_req_rd,
  input  logic [19:0]                      s_ctrlport_req_addr,
  input  logic [31:0]                      s_ctrlport_req_data,
  output logic                             s_ctrlport_resp_ack,
  output logic [31:0]                      s_ctrlport_resp_data,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_en,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_out,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_in_fabric,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_out_fabric,
  output logic                             irq
);

  localparam int W = NUM_PORTS * PORT_WIDTH;
  localparam logic [19:0] BASE_ADDR = 20'(REG_BASE);
  localparam logic [19:0] WINDOW    = 20'(NUM_PORTS * PORT_STRIDE);

  logic [19:0]               rel_addr;
  logic                      in_window;
  logic [PORT_IDX_WIDTH-1:0] port_idx;
  reg_offset_t               offset;
  logic                      wr_req;
  logic                      rd_req;
  logic                      access_ok;
  logic [PORT_WIDTH-1:0]     wdata;
  logic [PORT_WIDTH-1:0]     rdata;
  logic                      unused_req_data;

  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] master_reg, direction_reg, output_reg;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] rise_en_reg, fall_en_reg, edge_status;
  logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] w1c_mask, filtered, rise_pulse, fall_pulse;
  logic [W-1:0] sync_in, master_flat, output_flat;

  assign wdata           = s_ctrlport_req_data[PORT_WIDTH-1:0];
  assign unused_req_data = ^s_ctrlport_req_data;

  // Decode the request into port and offset; writes win over reads.
  always_comb begin
    rel_addr  = s_ctrlport_req_addr - BASE_ADDR;
    in_window = (s_ctrlport_req_addr >= BASE_ADDR) && (rel_addr < WINDOW);
    port_idx  = rel_addr[OFFSET_WIDTH +: PORT_IDX_WIDTH];
    offset    = rel_addr[OFFSET_WIDTH-1:0];
    wr_req    = s_ctrlport_req_wr;
    rd_req    = s_ctrlport_req_rd & ~s_ctrlport_req_wr;
    access_ok = in_window && ((wr_req && offset_writable(offset)) ||
                              (rd_req && offset_readable(offset)));
  end

  // Select the read value of the addressed port register.
  always_comb begin
    rdata    = '0;
    w1c_mask = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_idx == PORT_IDX_WIDTH'(p)) begin
        case (offset)
          OFF_MASTER:      rdata = master_reg[p];
          OFF_DIRECTION:   rdata = direction_reg[p];
          OFF_INPUT:       rdata = filtered[p];
          OFF_OUTPUT:      rdata = output_reg[p];
          OFF_EDGE_STATUS: rdata = edge_status[p];
          OFF_RISE_EN:     rdata = rise_en_reg[p];
          OFF_FALL_EN:     rdata = fall_en_reg[p];
          default:         rdata = '0;
        endcase
        if (in_window && wr_req && offset == OFF_EDGE_STATUS) begin
          w1c_mask[p] = wdata;
        end
      end
    end
  end

  // Apply register writes, including the atomic set/clear of OUTPUT.
  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      master_reg    <= '0;
      direction_reg <= '0;
      output_reg    <= '0;
      rise_en_reg   <= '0;
      fall_en_reg   <= '0;
    end else if (wr_req && in_window) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_idx == PORT_IDX_WIDTH'(p)) begin
          case (offset)
            OFF_MASTER:     master_reg[p]    <= wdata;
            OFF_DIRECTION:  direction_reg[p] <= wdata;
            OFF_OUTPUT:     output_reg[p]    <= wdata;
            OFF_OUTPUT_SET: output_reg[p]    <= output_reg[p] | wdata;
            OFF_OUTPUT_CLR: output_reg[p]    <= output_reg[p] & ~wdata;
            OFF_RISE_EN:    rise_en_reg[p]   <= wdata;
            OFF_FALL_EN:    fall_en_reg[p]   <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // Latch enabled edges; a new edge overrides a same-cycle W1C.
  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      edge_status <= '0;
    end else begin
      edge_status <= (edge_status & ~w1c_mask) |
                     (rise_pulse & rise_en_reg) | (fall_pulse & fall_en_reg);
    end
  end

  // Level interrupt follows any pending status one cycle later.
  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |edge_status;
    end
  end

  // Register the ctrlport response; only decoded reads return data.
  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      s_ctrlport_resp_ack  <= 1'b0;
      s_ctrlport_resp_data <= '0;
    end else begin
      s_ctrlport_resp_ack  <= access_ok;
      s_ctrlport_resp_data <= (access_ok && rd_req) ? MAX_PORT_WIDTH'(rdata) : '0;
    end
  end

  synchronizer #(.WIDTH(W), .STAGES(2)) u_sync (
    .clk (ctrlport_clk),
    .rst (ctrlport_rst),
    .d   (gpio_in),
    .q   (sync_in)
  );

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    x4xx_dio_line_filter #(
      .WIDTH           (PORT_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
      .clk      (ctrlport_clk),
      .rst      (ctrlport_rst),
      .sync_in  (sync_in[p*PORT_WIDTH +: PORT_WIDTH]),
      .filtered (filtered[p]),
      .rise     (rise_pulse[p]),
      .fall     (fall_pulse[p])
    );
  end

  assign master_flat = master_reg;
  assign output_flat = output_reg;

  glitch_free_mux #(.WIDTH(W)) u_out_mux (
    .sel (master_flat),
    .a   (output_flat),
    .b   (gpio_out_fabric),
    .y   (gpio_out)
  );

  assign gpio_en        = direction_reg;
  assign gpio_in_fabric = gpio_in;

endmodule
